// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: FSM state type, port ids
// and the default watchdog limit.
// Ports: none (package).
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   // Cycles mem_req may stay high without mem_ack before the abort.
   localparam int DEFAULT_TIMEOUT = 16;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arb_pick.sv
// ---------------------------------------------------------------------------
// dmem_arb_pick
// Combinational winner select for the two requesters. Holds the whole
// round-robin / fixed-priority policy so the arbiter FSM is build-agnostic.
//
// Build option: DMEM_ARB_RR_EN
//   defined   - round-robin: after any grant the pointer moves to the other port
//   undefined - fixed priority: the pointer is held at the cpu port
//
// Ports:
//   i_cpu_req, i_dma_req : live request lines
//   i_prio_ptr           : port that wins a contested cycle
//   o_any                : at least one request is present
//   o_winner             : port to grant (PORT_CPU / PORT_DMA)
//   o_next_ptr           : value the priority pointer takes after this grant
// ---------------------------------------------------------------------------
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic i_cpu_req,
   input  logic i_dma_req,
   input  logic i_prio_ptr,
   output logic o_any,
   output logic o_winner,
   output logic o_next_ptr
);

   assign o_any = i_cpu_req | i_dma_req;

   // A lone requester always wins; the pointer only breaks ties.
   assign o_winner = (i_cpu_req && i_dma_req) ? i_prio_ptr
                   : (i_dma_req ? PORT_DMA : PORT_CPU);

`ifdef DMEM_ARB_RR_EN
   assign o_next_ptr = ~o_winner;
`else
   assign o_next_ptr = PORT_CPU;
`endif

endmodule : dmem_arb_pick

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported data memory between the cpu load/store path
// (port 0) and a DMA/loader (port 1). One memory transaction is outstanding
// at a time; it retires with a one-cycle response pulse to its owner. A
// watchdog aborts a request the memory never acknowledges (rsp_err = 1).
// Arbitration policy is selected in dmem_arb_pick by DMEM_ARB_RR_EN.
//
// Ports (all outputs registered, all reset to 0):
//   i_clk, i_reset                : clock, asynchronous active-low reset
//   i_cpu_* / i_dma_*             : req, we, addr, wdata per requester
//   o_cpu_gnt / o_dma_gnt         : one-cycle accept pulse
//   o_cpu_rsp_valid/o_dma_rsp_valid: one-cycle completion pulse
//   o_rsp_rdata, o_rsp_err        : completion data / timeout flag (held)
//   o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata : memory request
//   i_mem_ack, i_mem_rdata        : memory completion and read data
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_gnt,
   output logic              o_cpu_rsp_valid,
   input  logic              i_dma_req,
   input  logic              i_dma_we,
   input  logic [ADDR_W-1:0] i_dma_addr,
   input  logic [DATA_W-1:0] i_dma_wdata,
   output logic              o_dma_gnt,
   output logic              o_dma_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam int              CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   arb_state_t       r_state;
   logic             r_owner;
   logic             r_prio_ptr;
   logic [CNT_W-1:0] r_cnt;

   logic w_any;
   logic w_winner;
   logic w_next_ptr;

   dmem_arb_pick u_pick (
      .i_cpu_req  (i_cpu_req),
      .i_dma_req  (i_dma_req),
      .i_prio_ptr (r_prio_ptr),
      .o_any      (w_any),
      .o_winner   (w_winner),
      .o_next_ptr (w_next_ptr)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state         <= ARB_IDLE;
         r_owner         <= PORT_CPU;
         r_prio_ptr      <= PORT_CPU;
         r_cnt           <= '0;
         o_cpu_gnt       <= 1'b0;
         o_dma_gnt       <= 1'b0;
         o_cpu_rsp_valid <= 1'b0;
         o_dma_rsp_valid <= 1'b0;
         o_rsp_rdata     <= '0;
         o_rsp_err       <= 1'b0;
         o_mem_req       <= 1'b0;
         o_mem_we        <= 1'b0;
         o_mem_addr      <= '0;
         o_mem_wdata     <= '0;
      end else begin
         // NOTE: pulse outputs default low here; the state branches below
         // raise them for exactly the one cycle they apply to.
         o_cpu_gnt       <= 1'b0;
         o_dma_gnt       <= 1'b0;
         o_cpu_rsp_valid <= 1'b0;
         o_dma_rsp_valid <= 1'b0;

         case (r_state)
            ARB_IDLE: begin
               if (w_any) begin
                  r_state    <= ARB_BUSY;
                  r_owner    <= w_winner;
                  r_prio_ptr <= w_next_ptr;
                  r_cnt      <= '0;
                  o_mem_req  <= 1'b1;
                  if (w_winner == PORT_DMA) begin
                     o_mem_we    <= i_dma_we;
                     o_mem_addr  <= i_dma_addr;
                     o_mem_wdata <= i_dma_wdata;
                     o_dma_gnt   <= 1'b1;
                  end else begin
                     o_mem_we    <= i_cpu_we;
                     o_mem_addr  <= i_cpu_addr;
                     o_mem_wdata <= i_cpu_wdata;
                     o_cpu_gnt   <= 1'b1;
                  end
               end
            end

            ARB_BUSY: begin
               // Ack has precedence over an expiring watchdog in the same cycle.
               if (i_mem_ack || (r_cnt == CNT_MAX)) begin
                  r_state     <= ARB_RESP;
                  o_mem_req   <= 1'b0;
                  o_rsp_err   <= ~i_mem_ack;
                  o_rsp_rdata <= (i_mem_ack && !o_mem_we) ? i_mem_rdata : '0;
                  if (r_owner == PORT_DMA) o_dma_rsp_valid <= 1'b1;
                  else                     o_cpu_rsp_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ARB_RESP: r_state <= ARB_IDLE;

            default:  r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule : dmem_arbiter
